// File: rtl/eth_tx_scheduler_if.sv
// rtl/eth_tx_scheduler_if.sv - CPU register bus and MAC handshake bundle for eth_tx_scheduler
interface eth_tx_scheduler_if;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [31:0] wdata;
    logic        rd_en;
    logic [1:0]  rd_sel;
    logic [31:0] rdata;
    logic [31:0] tx_data;
    logic        tx_ena;
    logic        tx_finish;
    logic [63:0] rx_data;
    logic        rx_new;

    modport master (
        output wr_en, wr_sel, wdata, rd_en, rd_sel, tx_finish, rx_data, rx_new,
        input  rdata, tx_data, tx_ena
    );

    modport slave (
        input  wr_en, wr_sel, wdata, rd_en, rd_sel, tx_finish, rx_data, rx_new,
        output rdata, tx_data, tx_ena
    );
endinterface

// File: rtl/eth_tx_scheduler.sv
// rtl/eth_tx_scheduler.sv - TX FIFO with four-phase MAC sequencer and RX frame holding register
module eth_tx_scheduler #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    eth_tx_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_head, r_tail;
    logic [AW:0]   r_count;
    logic [TW-1:0] r_timer;
    logic [31:0]   r_tx_data;
    logic          r_tx_ena;
    logic          r_rx_new_s, r_rx_new_p;
    logic [63:0]   r_rx_data_s, r_rx_reg;
    logic          r_rx_valid, r_rx_overrun, r_tx_timeout, r_tx_drop;

    logic w_ctrl, w_clear, w_flush, w_abort, w_push_req, w_push_ok;
    logic w_empty, w_full, w_pop, w_tmo, w_timer_clr, w_ena_nxt;
    logic w_cap, w_rx_pop;

    assign w_ctrl     = bus.wr_en && (bus.wr_sel == 2'd1);
    assign w_clear    = w_ctrl && bus.wdata[0];
    assign w_flush    = w_ctrl && bus.wdata[1];
    assign w_abort    = w_ctrl && bus.wdata[2];
    assign w_push_req = bus.wr_en && (bus.wr_sel == 2'd0);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (AW+1)'(DEPTH));
    // A full FIFO still accepts a push when the same cycle frees a slot (pop or flush).
    assign w_push_ok  = w_push_req && (!w_full || w_pop || w_flush);
    assign w_cap      = r_rx_new_s && !r_rx_new_p;
    assign w_rx_pop   = bus.rd_en && (bus.rd_sel == 2'd3);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tmo       = 1'b0;
        w_timer_clr = 1'b0;
        w_ena_nxt   = r_tx_ena;
        case (r_state)
            IDLE: begin
                if (!w_empty && !bus.tx_finish && !w_flush) begin
                    w_pop       = 1'b1;
                    w_ena_nxt   = 1'b1;
                    w_timer_clr = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_abort) begin
                    w_ena_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else if (bus.tx_finish) begin
                    w_ena_nxt   = 1'b0;
                    w_timer_clr = 1'b1;
                    w_state_nxt = WAIT_LOW;
                end else if (r_timer == TLIM) begin
                    w_ena_nxt   = 1'b0;
                    w_tmo       = 1'b1;
                    w_state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (w_abort || !bus.tx_finish) begin
                    w_state_nxt = IDLE;
                end else if (r_timer == TLIM) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_tail] <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_timer   <= '0;
            r_tx_data <= '0;
            r_tx_ena  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tx_ena <= w_ena_nxt;
            if (w_pop) begin
                r_tx_data <= r_mem[r_head];
            end
            // Flush realigns head to tail; a same-cycle push becomes the only entry.
            if (w_flush) begin
                r_head  <= r_tail;
                r_tail  <= w_push_ok ? r_tail + 1'b1 : r_tail;
                r_count <= w_push_ok ? (AW+1)'(1) : '0;
            end else begin
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                if (w_push_ok) begin
                    r_tail <= r_tail + 1'b1;
                end
                r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
            end
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (r_state != IDLE && r_timer != '1) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_new_s   <= 1'b0;
            r_rx_new_p   <= 1'b0;
            r_rx_data_s  <= '0;
            r_rx_reg     <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_tx_timeout <= 1'b0;
            r_tx_drop    <= 1'b0;
        end else begin
            r_rx_new_s  <= bus.rx_new;
            r_rx_data_s <= bus.rx_data;
            r_rx_new_p  <= r_rx_new_s;
            if (w_cap) begin
                r_rx_reg   <= r_rx_data_s;
                r_rx_valid <= 1'b1;
            end else if (w_rx_pop) begin
                r_rx_valid <= 1'b0;
            end
            // Sticky flags: a new event in the clearing cycle is kept.
            if (w_cap && r_rx_valid && !w_rx_pop) begin
                r_rx_overrun <= 1'b1;
            end else if (w_clear) begin
                r_rx_overrun <= 1'b0;
            end
            if (w_tmo) begin
                r_tx_timeout <= 1'b1;
            end else if (w_clear) begin
                r_tx_timeout <= 1'b0;
            end
            if (w_push_req && !w_push_ok) begin
                r_tx_drop <= 1'b1;
            end else if (w_clear) begin
                r_tx_drop <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.rd_sel)
            2'd0: bus.rdata = {17'd0, r_tx_drop, r_tx_timeout, r_rx_overrun, r_rx_valid,
                               (r_state != IDLE), w_full, w_empty, 8'(r_count)};
            2'd1: bus.rdata = r_rx_reg[63:32];
            default: bus.rdata = r_rx_reg[31:0];
        endcase
    end

    assign bus.tx_data = r_tx_data;
    assign bus.tx_ena  = r_tx_ena;
endmodule

// File: tb/tb_eth_tx_scheduler.sv
// tb/tb_eth_tx_scheduler.sv - scoreboard bench for eth_tx_scheduler with MAC responder
module tb_eth_tx_scheduler;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    eth_tx_scheduler_if bus();

    eth_tx_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int n_rise   = 0;

    logic [31:0] mfifo[$];
    int          exp_dur[$];
    int          resp_mode = 0;
    bit          resp_rand = 0;
    int          resp_k = 3;
    int          resp_h = 2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        if (mfifo.size() < DEPTH) mfifo.push_back(w);
        bus.wr_en = 1'b1; bus.wr_sel = 2'd0; bus.wdata = w;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic ctrl(input logic [31:0] v);
        bus.wr_en = 1'b1; bus.wr_sel = 2'd1; bus.wdata = v;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] sel, output logic [31:0] d);
        bus.rd_en = 1'b1; bus.rd_sel = sel;
        #1 d = bus.rdata;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic rx_pulse(input logic [63:0] f);
        bus.rx_data = f; bus.rx_new = 1'b1;
        tick();
        bus.rx_new = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input int budget);
        logic [31:0] s;
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            cpu_read(2'd0, s);
            if (!s[10] && s[7:0] == 8'd0) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_err++;
            $display("FAIL drain: still busy after %0d reads, required idle and empty", budget);
        end
    endtask

    // MAC responder: answers each request according to the current mode.
    initial begin
        int k, h;
        bus.tx_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_ena) begin
                if (resp_mode == 0) begin
                    k = resp_rand ? int'($urandom_range(1, 5)) : resp_k;
                    h = resp_rand ? int'($urandom_range(1, 3)) : resp_h;
                    exp_dur.push_back(k + 1);
                    repeat (k) @(posedge clk);
                    #1 bus.tx_finish = 1'b1;
                    repeat (h) @(posedge clk);
                    #1 bus.tx_finish = 1'b0;
                end else begin
                    exp_dur.push_back(resp_mode == 1 ? TIMEOUT : -1);
                    for (int i = 0; i < 200 && bus.tx_ena; i++) @(negedge clk);
                end
            end
        end
    end

    // Monitor: each tx_ena rise consumes the oldest expected word.
    logic        prev_ena = 1'b0;
    logic [31:0] cur_word;
    int          dur;
    bit          unstable;
    always @(negedge clk) begin
        int d;
        logic [31:0] ew;
        if (bus.tx_ena && !prev_ena) begin
            n_rise++;
            cur_word = bus.tx_data; dur = 1; unstable = 0;
            if (mfifo.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL tx_unexpected: got word %h, required no send", bus.tx_data);
            end else begin
                ew = mfifo.pop_front();
                check("tx_word", bus.tx_data, ew);
            end
        end else if (bus.tx_ena) begin
            dur++;
            if (bus.tx_data !== cur_word) unstable = 1;
        end else if (prev_ena) begin
            check("tx_stable", unstable, 0);
            if (exp_dur.size() != 0) begin
                d = exp_dur.pop_front();
                if (d >= 0) check("tx_ena_cycles", dur, d);
            end
        end
        prev_ena = bus.tx_ena;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic [63:0] f;
        int n0;
        bus.wr_en = 0; bus.wr_sel = 0; bus.wdata = 0;
        bus.rd_en = 0; bus.rd_sel = 0;
        bus.rx_data = 0; bus.rx_new = 0;
        repeat (3) tick();
        check("rst_tx_ena", bus.tx_ena, 0);
        check("rst_tx_data", bus.tx_data, 0);
        cpu_read(2'd0, s); check("rst_status", s, 32'h100);
        reset = 1'b1;
        tick();

        // Single word, finish after 3 cycles, low 2 later.
        resp_mode = 0; resp_rand = 0; resp_k = 3; resp_h = 2;
        push(32'hDEADBEEF);
        check("lat_before", bus.tx_ena, 0);
        tick();
        check("lat_rise", bus.tx_ena, 1);
        wait_drain(50);
        cpu_read(2'd0, s); check("single_idle_status", s, 32'h100);

        // Stalled MAC: fill, overflow, clear, then timeouts drain the FIFO.
        resp_mode = 1;
        for (int i = 0; i < 9; i++) push(32'hA000_0000 + i);
        cpu_read(2'd0, s); check("full_no_drop", s, 32'h608);
        push(32'hA000_0009);
        cpu_read(2'd0, s); check("full_drop", s, 32'h4608);
        ctrl(32'h1);
        cpu_read(2'd0, s); check("drop_cleared", s, 32'h608);
        wait_drain(400);
        cpu_read(2'd0, s); check("timeout_flag", s, 32'h2100);
        ctrl(32'h1);
        cpu_read(2'd0, s); check("timeout_cleared", s, 32'h100);

        // RX capture, overrun, pop.
        rx_pulse(64'h1122334455667788);
        cpu_read(2'd1, s); check("rx_hi", s, 32'h11223344);
        cpu_read(2'd2, s); check("rx_lo", s, 32'h55667788);
        cpu_read(2'd0, s); check("rx_valid", s, 32'h900);
        rx_pulse(64'hAAAA_BBBB_CCCC_DDDD);
        cpu_read(2'd0, s); check("rx_overrun", s, 32'h1900);
        cpu_read(2'd3, s); check("rx_pop_lo", s, 32'hCCCCDDDD);
        cpu_read(2'd0, s); check("rx_popped", s, 32'h1100);
        ctrl(32'h1);
        rx_pulse(64'h0F0F_0F0F_1234_5678);
        bus.rx_data = 64'hCAFE_F00D_8765_4321; bus.rx_new = 1'b1;
        tick();
        bus.rx_new = 1'b0;
        cpu_read(2'd3, s);
        cpu_read(2'd0, s); check("cap_pop_status", s, 32'h900);
        cpu_read(2'd1, s); check("cap_pop_hi", s, 32'hCAFEF00D);
        cpu_read(2'd3, s); check("cap_pop_lo", s, 32'h87654321);
        for (int i = 0; i < 4; i++) begin
            f = {$urandom, $urandom};
            rx_pulse(f);
            cpu_read(2'd1, s); check("rx_rand_hi", s, f[63:32]);
            cpu_read(2'd3, s); check("rx_rand_lo", s, f[31:0]);
            cpu_read(2'd0, s); check("rx_rand_status", s, 32'h100);
        end

        // Random TX traffic with random MAC response times.
        resp_mode = 0; resp_rand = 1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            for (int g = 0; g < 100 && mfifo.size() >= DEPTH - 1; g++) tick();
            push($urandom);
        end
        wait_drain(800);
        check("rand_all_sent", mfifo.size(), 0);

        // Flush while word 1 is in SEND.
        resp_rand = 0; resp_k = 3; resp_h = 2;
        n0 = n_rise;
        push(32'h1111_0001); push(32'h1111_0002); push(32'h1111_0003);
        ctrl(32'h2);
        mfifo.delete();
        cpu_read(2'd0, s); check("flush_status", s, 32'h500);
        wait_drain(50);
        repeat (20) tick();
        check("flush_sends", n_rise - n0, 1);

        // Abort mid-handshake: word lost, no flags.
        resp_mode = 2;
        push(32'h2222_0001);
        repeat (3) tick();
        ctrl(32'h4);
        check("abort_ena", bus.tx_ena, 0);
        cpu_read(2'd0, s); check("abort_status", s, 32'h100);

        // Reset while a word is in flight and 5 are queued.
        for (int i = 0; i < 6; i++) push(32'h3333_0000 + i);
        cpu_read(2'd0, s); check("pre_reset_status", s, 32'h405);
        check("pre_reset_ena", bus.tx_ena, 1);
        reset = 1'b0;
        tick();
        mfifo.delete();
        check("mid_reset_ena", bus.tx_ena, 0);
        check("mid_reset_data", bus.tx_data, 0);
        cpu_read(2'd0, s); check("mid_reset_status", s, 32'h100);
        reset = 1'b1;
        repeat (10) tick();
        check("post_reset_ena", bus.tx_ena, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
